// File: rtl/x_wb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : x_wb_arbiter_if
// Brief    : Scalar write-back, vector result handshake and register-file
//            write port bundle for the X register-file write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface x_wb_arbiter_if;
    logic        s_wen;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic        s_stall;
    logic        v_valid;
    logic        v_ready;
    logic [4:0]  v_rd;
    logic [31:0] v_data;
    logic        reg_w;
    logic [4:0]  rd;
    logic [31:0] w_data;

    // Arbiter side
    modport slave (
        input  s_wen, s_rd, s_data, v_valid, v_rd, v_data,
        output s_stall, v_ready, reg_w, rd, w_data
    );

    // Pipeline / vector unit / register-file side
    modport master (
        output s_wen, s_rd, s_data, v_valid, v_rd, v_data,
        input  s_stall, v_ready, reg_w, rd, w_data
    );
endinterface
`default_nettype wire

// File: rtl/x_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : x_wb_arbiter
// Brief    : Merges scalar write-back and buffered vector scalar results into
//            the X register file write port. Scalar has priority; a starvation
//            counter raises s_stall so vector results drain.
//            Optional: `define XWB_PENDING_EN adds the pend_mask output.
// Revision : 1.0 - initial release
// ============================================================================
module x_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    x_wb_arbiter_if.slave               bus,
    output logic [$clog2(DEPTH):0]      fifo_count
`ifdef XWB_PENDING_EN
    ,
    output logic [31:0]                 pend_mask
`endif
);

    localparam int                 PTR_W        = $clog2(DEPTH);
    localparam int                 CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0]   c_DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [7:0]         c_STARVE_MAX = 8'(STARVE_MAX);

    logic [4:0]       r_mem_rd   [DEPTH];
    logic [31:0]      r_mem_data [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_starve;
    logic             r_reg_w;
    logic [4:0]       r_rd;
    logic [31:0]      r_wdata;

    logic             w_v_ready;
    logic             w_empty;
    logic             w_s_req;
    logic             w_v_keep;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [4:0]       w_iss_rd;
    logic [31:0]      w_iss_data;

    assign w_v_ready = (r_count < c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);
    assign w_s_req   = bus.s_wen && (bus.s_rd != 5'd0);
    // Handshaken entries targeting x0 are consumed here and never stored.
    assign w_v_keep  = bus.v_valid && w_v_ready && (bus.v_rd != 5'd0);
    assign w_pop     = !w_s_req && !w_empty;
    assign w_push    = w_v_keep && (w_s_req || !w_empty);

    always_comb begin
        w_issue    = 1'b0;
        w_iss_rd   = r_rd;
        w_iss_data = r_wdata;
        if (w_s_req) begin
            w_issue    = 1'b1;
            w_iss_rd   = bus.s_rd;
            w_iss_data = bus.s_data;
        end else if (!w_empty) begin
            w_issue    = 1'b1;
            w_iss_rd   = r_mem_rd[r_rptr];
            w_iss_data = r_mem_data[r_rptr];
        end else if (w_v_keep) begin
            w_issue    = 1'b1;
            w_iss_rd   = bus.v_rd;
            w_iss_data = bus.v_data;
        end
    end

    // Storage carries no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= bus.v_rd;
            r_mem_data[r_wptr] <= bus.v_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_reg_w  <= 1'b0;
            r_rd     <= '0;
            r_wdata  <= '0;
        end else begin
            r_reg_w <= w_issue;
            if (w_issue) begin
                r_rd    <= w_iss_rd;
                r_wdata <= w_iss_data;
            end
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A stalled-but-ignored scalar keeps the counter saturated.
            if (w_pop || w_empty)
                r_starve <= '0;
            else if (w_s_req && (r_starve != c_STARVE_MAX))
                r_starve <= r_starve + 8'd1;
        end
    end

    assign bus.v_ready = w_v_ready;
    assign bus.s_stall = (r_starve == c_STARVE_MAX);
    assign bus.reg_w   = r_reg_w;
    assign bus.rd      = r_rd;
    assign bus.w_data  = r_wdata;
    assign fifo_count  = r_count;

`ifdef XWB_PENDING_EN
    logic [31:0]      w_pend;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        w_pend = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rptr + PTR_W'(k);
            if (CNT_W'(k) < r_count)
                w_pend[r_mem_rd[w_idx]] = 1'b1;
        end
        if (r_reg_w)
            w_pend[r_rd] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign pend_mask = w_pend;
`endif

endmodule
`default_nettype wire

// File: tb/tb_x_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_x_wb_arbiter
// Brief    : Directed scoreboard bench for x_wb_arbiter (DEPTH=4, STARVE_MAX=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  fifo_count;
`ifdef XWB_PENDING_EN
    logic [31:0] pend_mask;
`endif

    x_wb_arbiter_if bus ();

    x_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_count (fifo_count)
`ifdef XWB_PENDING_EN
        ,
        .pend_mask  (pend_mask)
`endif
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    // Monitor: every register-file write must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.reg_w) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h required no write",
                             bus.rd, bus.w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rd !== e.rd || bus.w_data !== e.data) begin
                        n_miss++;
                        $display("FAIL write_order: got rd=%0d data=%h required rd=%0d data=%h",
                                 bus.rd, bus.w_data, e.rd, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic sw, input logic [4:0] srd, input logic [31:0] sd,
                         input logic vv, input logic [4:0] vrd, input logic [31:0] vd);
        bus.s_wen   = sw;
        bus.s_rd    = srd;
        bus.s_data  = sd;
        bus.v_valid = vv;
        bus.v_rd    = vrd;
        bus.v_data  = vd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_w",   {31'b0, bus.reg_w},   32'd0);
        chk("rst_rd",      {27'b0, bus.rd},      32'd0);
        chk("rst_w_data",  bus.w_data,           32'd0);
        chk("rst_count",   {29'b0, fifo_count},  32'd0);
        chk("rst_v_ready", {31'b0, bus.v_ready}, 32'd1);
        chk("rst_s_stall", {31'b0, bus.s_stall}, 32'd0);
        rst_n = 1'b1;
        step();

        // Scalar alone, then a scalar request to x0 is ignored.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        push(5'd5, 32'hDEADBEEF);
        step();
        chk("scalar_reg_w", {31'b0, bus.reg_w}, 32'd1);
        drive(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0);
        step();
        chk("scalar_x0_reg_w", {31'b0, bus.reg_w}, 32'd0);
        chk("hold_rd",         {27'b0, bus.rd},    32'd5);
        chk("hold_w_data",     bus.w_data,         32'hDEADBEEF);

        // Vector bypass with empty FIFO.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h00001234);
        push(5'd10, 32'h00001234);
        step();
        chk("bypass_reg_w", {31'b0, bus.reg_w},  32'd1);
        chk("bypass_count", {29'b0, fifo_count}, 32'd0);
        idle();
        step();

        // Collision and fill: scalar every cycle, vector rd=1..5.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(20 + i), 32'hA000 + i, 1'b1, 5'(i), 32'hB000 + i);
            push(5'(20 + i), 32'hA000 + i);
            step();
            chk("fill_count", {29'b0, fifo_count}, i);
        end
        drive(1'b1, 5'd25, 32'hA005, 1'b1, 5'd5, 32'hB005);
        push(5'd25, 32'hA005);
        chk("full_v_ready", {31'b0, bus.v_ready}, 32'd0);
        step();
        chk("full_count",   {29'b0, fifo_count}, 32'd4);
        chk("fill_s_stall", {31'b0, bus.s_stall}, 32'd0);
        for (int i = 1; i <= 5; i++) push(5'(i), 32'hB000 + i);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hB005);
        step();
        chk("drain1_count",   {29'b0, fifo_count}, 32'd3);
        chk("drain1_v_ready", {31'b0, bus.v_ready}, 32'd1);
        step();
        chk("push_pop_count", {29'b0, fifo_count}, 32'd3);
        idle();
        for (int i = 2; i >= 0; i--) begin
            step();
            chk("drain_count", {29'b0, fifo_count}, i);
        end
        step();
        chk("drained_reg_w", {31'b0, bus.reg_w}, 32'd0);

        // Starvation: one buffered entry, 8 scalar wins, one stall violation.
        drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd9, 32'h99);
        push(5'd7, 32'h70);
        step();
        chk("starve_count", {29'b0, fifo_count}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(16 + i), 32'hC0 + i, 1'b0, 5'd0, 32'h0);
            push(5'(16 + i), 32'hC0 + i);
            step();
            if (i == 6) chk("starve7_s_stall", {31'b0, bus.s_stall}, 32'd0);
        end
        chk("starve8_s_stall", {31'b0, bus.s_stall}, 32'd1);
        drive(1'b1, 5'd31, 32'hFFFF0000, 1'b0, 5'd0, 32'h0);
        push(5'd31, 32'hFFFF0000);
        step();
        chk("violate_s_stall", {31'b0, bus.s_stall}, 32'd1);
        chk("violate_count",   {29'b0, fifo_count},  32'd1);
        idle();
        push(5'd9, 32'h99);
        step();
        chk("unstall_s_stall", {31'b0, bus.s_stall}, 32'd0);
        chk("unstall_count",   {29'b0, fifo_count},  32'd0);

        // Pending mask: FIFO {3,7}, then a dropped v_rd=0 entry.
        drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd3, 32'h33);
        push(5'd12, 32'h12);
        step();
        drive(1'b1, 5'd13, 32'h13, 1'b1, 5'd7, 32'h77);
        push(5'd13, 32'h13);
        step();
`ifdef XWB_PENDING_EN
        chk("pend_fifo_out", pend_mask, 32'h00002088);
`endif
        drive(1'b1, 5'd7, 32'h7007, 1'b1, 5'd0, 32'hEEEE);
        push(5'd7, 32'h7007);
        step();
        chk("drop_x0_count", {29'b0, fifo_count}, 32'd2);
`ifdef XWB_PENDING_EN
        chk("pend_3_7", pend_mask, 32'h00000088);
`endif
        idle();
        push(5'd3, 32'h33);
        push(5'd7, 32'h77);
        step();
        step();
`ifdef XWB_PENDING_EN
        chk("pend_last", pend_mask, 32'h00000080);
`endif
        step();
        chk("pend_drained_count", {29'b0, fifo_count}, 32'd0);

        // Reset mid-traffic with three buffered entries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(26 + i), 32'hE0 + i, 1'b1, 5'(1 + i), 32'hD0 + i);
            push(5'(26 + i), 32'hE0 + i);
            step();
        end
        chk("pre_reset_count", {29'b0, fifo_count}, 32'd3);
        #5;
        rst_n = 1'b0;
        idle();
        #1;
        chk("async_rst_reg_w",   {31'b0, bus.reg_w},   32'd0);
        chk("async_rst_count",   {29'b0, fifo_count},  32'd0);
        chk("async_rst_v_ready", {31'b0, bus.v_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) step();
        chk("post_reset_reg_w", {31'b0, bus.reg_w},  32'd0);
        chk("post_reset_count", {29'b0, fifo_count}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/x_wb_arbiter.md
Name: x_wb_arbiter

Overview:
- Write-back stage directly upstream of the scalar X register file. It merges two write sources into the file's single write port (reg_w / rd / w_data).
- Source 1 is the scalar pipeline write-back, which has no backpressure.
- Source 2 is vector-unit scalar results (vsetvl vl return, vmv.x.s, vcpop/vfirst). These arrive on a valid/ready handshake and are buffered in a small FIFO.
- Scalar always has priority; a starvation counter requests a one-cycle scalar stall so vector results drain.

Parameters:
- DEPTH, 4, vector FIFO entries (power of two, 2..16)
- STARVE_MAX, 8, consecutive lost arbitrations before s_stall asserts (1..255)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_wen  in  1  scalar write request this cycle
- s_rd  in  5  scalar destination register
- s_data  in  32  scalar write data
- s_stall  out  1  request to scalar pipeline: issue no write this cycle
- v_valid  in  1  vector result valid
- v_ready  out  1  FIFO can accept
- v_rd  in  5  vector result destination
- v_data  in  32  vector result data
- reg_w  out  1  register-file write enable (registered)
- rd  out  5  register-file write address (registered)
- w_data  out  32  register-file write data (registered)
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): reg_w=0, rd=0, w_data=0, FIFO empty, fifo_count=0, starve_cnt=0, s_stall=0, v_ready=1. Takes effect immediately, mid-operation included; FIFO contents and any in-flight write are discarded.
- Outputs reg_w/rd/w_data are registered: a winner selected in cycle N is presented in cycle N+1. Latency is 1 for scalar and for the vector bypass.
- Vector acceptance:
  - v_ready = (fifo_count < DEPTH). It depends only on registered state, with no combinational path from v_valid.
  - A handshake is v_valid && v_ready.
  - A full FIFO does not accept, even if it pops in the same cycle.
- rd=0 filtering: an s_wen with s_rd=0 is ignored (counts as no request). A handshaken vector entry with v_rd=0 is consumed and dropped, never stored.
- Arbitration, each cycle, first match wins:
  1. s_wen && s_rd!=0: issue scalar. Any handshaken vector entry is pushed.
  2. FIFO non-empty: pop head and issue it. A simultaneous handshake pushes; count is unchanged.
  3. FIFO empty and handshake with v_rd!=0: bypass, issue the vector entry directly; nothing stored.
  4. Otherwise reg_w=0 next cycle, and rd/w_data hold their previous values.
- Ordering:
  - FIFO order preserved among vector entries.
  - No ordering is guaranteed between sources. Same-rd conflicts are resolved by the hazard unit, not here.
- Starvation:
  - starve_cnt (8-bit) increments when rule 1 fires while the FIFO is non-empty, saturating at STARVE_MAX.
  - It clears to 0 on any pop or whenever the FIFO is empty.
  - s_stall = (starve_cnt == STARVE_MAX), decoded from the register.
  - Upstream must hold s_wen=0 while s_stall=1. If it violates this, the scalar still wins (no write lost) and the counter stays saturated.
- FIFO: circular buffer with log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH. fifo_count is a separate registered counter: +1 on push only, -1 on pop only, unchanged on both.

Optional Feature:
- Macro XWB_PENDING_EN.
- Defined: adds output pend_mask [31:0].
  - Bit r is set when any FIFO entry, or the registered output with reg_w=1, targets r.
  - Recomputed from registered state every cycle; bit 0 is always 0.
  - Used by the hazard unit to stall same-rd scalar reads/writes.
- Undefined: port absent, no extra logic.

Test Plan:
- Reset mid-traffic: FIFO holding 3 entries, rst_n pulsed low → reg_w=0, fifo_count=0, v_ready=1 immediately, no further writes after release.
- Scalar alone: s_wen=1, s_rd=5, s_data=0xDEADBEEF → next cycle reg_w=1, rd=5, w_data=0xDEADBEEF; s_rd=0 → reg_w=0.
- Vector bypass: FIFO empty, scalar idle, v_valid=1, v_rd=10, v_data=0x1234 → next cycle reg_w=1, rd=10, w_data=0x1234; fifo_count stays 0.
- Collision and fill: scalar writes every cycle while vector sends rd=1..5 (DEPTH=4) → entries 1..4 stored, v_ready=0 at count 4; on scalar idle, writes rd=1,2,3,4 in order, then rd=5 accepted.
- Starvation: FIFO non-empty, scalar writes 8 consecutive cycles (STARVE_MAX=8) → s_stall=1; with s_wen=0 the head pops, starve_cnt=0, s_stall=0.
- XWB_PENDING_EN: FIFO holds rd=3 and rd=7 → pend_mask=0x00000088; v_rd=0 accepted → dropped, pend_mask bit 0 stays 0.
